// File: rtl/sal_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : sal_sched_pkg
// Brief  : Shared command encoding and width helpers for the DDR2 scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package sal_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sal_cmd_t;

    localparam int DEFAULT_NUM_BANKS = 4;
    localparam int BA_WIDTH          = $clog2(DEFAULT_NUM_BANKS);

    function automatic int sal_ba_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int sal_addr_width(input int ra_width, input int ca_width);
        return (ra_width > ca_width) ? ra_width : ca_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sal_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sal_rr_arbiter
// Brief  : Round-robin pick of the first request at or after the pointer.
// Rev    : 1.0  initial release
// ============================================================================
module sal_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] w_cand;

    // NUM_REQ is a power of two, so the index add wraps naturally.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = ptr_i + IDX_W'(i);
            if (!any_o && req_i[w_cand]) begin
                any_o = 1'b1;
                idx_o = w_cand;
            end
        end
        gnt_o[idx_o] = any_o;
    end

endmodule
`default_nettype wire

// File: rtl/sal_timing_cntr.sv
`default_nettype none
// ============================================================================
// Module : sal_timing_cntr
// Brief  : Reloadable saturating down-counter; loads max(t-1,0) on load_i.
// Rev    : 1.0  initial release
// ============================================================================
module sal_timing_cntr #(
    parameter int T_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [T_WIDTH-1:0] val_i,
    output logic               zero_o
);

    logic [T_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= (val_i == '0) ? '0 : val_i - 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sal_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module : sal_cmd_sched
// Brief  : One-rank DDR2 command scheduler gating tRRD/tCCD/tWTR/tRTW.
// Rev    : 1.0  initial release
// ============================================================================
module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int T_WIDTH   = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_BANKS-1:0]                       act_req_i,
    input  logic [NUM_BANKS-1:0]                       rd_req_i,
    input  logic [NUM_BANKS-1:0]                       wr_req_i,
    input  logic [NUM_BANKS-1:0]                       pre_req_i,
    input  logic [NUM_BANKS-1:0]                       ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]              ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]              ca_i,
    output logic [NUM_BANKS-1:0]                       act_gnt_o,
    output logic [NUM_BANKS-1:0]                       rd_gnt_o,
    output logic [NUM_BANKS-1:0]                       wr_gnt_o,
    output logic [NUM_BANKS-1:0]                       pre_gnt_o,
    output logic [NUM_BANKS-1:0]                       ref_gnt_o,
    input  logic [T_WIDTH-1:0]                         t_rrd_i,
    input  logic [T_WIDTH-1:0]                         t_ccd_i,
    input  logic [T_WIDTH-1:0]                         t_wtr_i,
    input  logic [T_WIDTH-1:0]                         t_rtw_i,
    output logic                                       cmd_valid_o,
    output logic [2:0]                                 cmd_o,
    output logic [sal_ba_width(NUM_BANKS)-1:0]         cmd_ba_o,
    output logic [sal_addr_width(RA_WIDTH,CA_WIDTH)-1:0] cmd_addr_o
);

    localparam int c_BA_W = sal_ba_width(NUM_BANKS);
    localparam int c_AW   = sal_addr_width(RA_WIDTH, CA_WIDTH);

    logic [c_BA_W-1:0]    r_col_ptr, r_row_ptr;
    logic                 w_rrd_zero, w_ccd_zero, w_wtr_zero, w_rtw_zero;
    logic [NUM_BANKS-1:0] w_rd_req, w_wr_req, w_act_req;
    logic [NUM_BANKS-1:0] w_rd_gnt, w_wr_gnt, w_pre_gnt, w_ref_gnt, w_act_gnt;
    logic [c_BA_W-1:0]    w_rd_idx, w_wr_idx, w_pre_idx, w_ref_idx, w_act_idx;
    logic                 w_rd_any, w_wr_any, w_pre_any, w_ref_any, w_act_any;
    logic [c_BA_W-1:0]    w_rd_dist, w_wr_dist, w_col_idx;
    logic                 w_pick_rd, w_col_gnt, w_row_gnt;
    sal_cmd_t             w_cmd, r_cmd;
    logic [c_BA_W-1:0]    w_ba, w_row_idx, r_ba;
    logic [c_AW-1:0]      w_addr, r_addr;
    logic                 r_valid;

    assign w_rd_req  = rd_req_i  & {NUM_BANKS{w_ccd_zero & w_wtr_zero}};
    assign w_wr_req  = wr_req_i  & {NUM_BANKS{w_ccd_zero & w_rtw_zero}};
    assign w_act_req = act_req_i & {NUM_BANKS{w_rrd_zero}};

    sal_rr_arbiter #(.NUM_REQ(NUM_BANKS), .IDX_W(c_BA_W)) u_arb_rd (
        .req_i(w_rd_req), .ptr_i(r_col_ptr), .gnt_o(w_rd_gnt), .idx_o(w_rd_idx), .any_o(w_rd_any));
    sal_rr_arbiter #(.NUM_REQ(NUM_BANKS), .IDX_W(c_BA_W)) u_arb_wr (
        .req_i(w_wr_req), .ptr_i(r_col_ptr), .gnt_o(w_wr_gnt), .idx_o(w_wr_idx), .any_o(w_wr_any));
    sal_rr_arbiter #(.NUM_REQ(NUM_BANKS), .IDX_W(c_BA_W)) u_arb_pre (
        .req_i(pre_req_i), .ptr_i(r_row_ptr), .gnt_o(w_pre_gnt), .idx_o(w_pre_idx), .any_o(w_pre_any));
    sal_rr_arbiter #(.NUM_REQ(NUM_BANKS), .IDX_W(c_BA_W)) u_arb_ref (
        .req_i(ref_req_i), .ptr_i(r_row_ptr), .gnt_o(w_ref_gnt), .idx_o(w_ref_idx), .any_o(w_ref_any));
    sal_rr_arbiter #(.NUM_REQ(NUM_BANKS), .IDX_W(c_BA_W)) u_arb_act (
        .req_i(w_act_req), .ptr_i(r_row_ptr), .gnt_o(w_act_gnt), .idx_o(w_act_idx), .any_o(w_act_any));

    // RD and WR share col_ptr: the winner nearer the pointer goes, RD on a tie.
    assign w_rd_dist = w_rd_idx - r_col_ptr;
    assign w_wr_dist = w_wr_idx - r_col_ptr;
    assign w_pick_rd = w_rd_any && (!w_wr_any || (w_rd_dist <= w_wr_dist));
    assign w_col_idx = w_pick_rd ? w_rd_idx : w_wr_idx;
    assign w_row_idx = w_pre_any ? w_pre_idx : (w_ref_any ? w_ref_idx : w_act_idx);

    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        w_cmd     = CMD_NOP;
        w_ba      = '0;
        w_addr    = '0;
        if (!rst) begin
            if (w_pick_rd) begin
                rd_gnt_o = w_rd_gnt;
                w_cmd    = CMD_RD;
            end else if (w_wr_any) begin
                wr_gnt_o = w_wr_gnt;
                w_cmd    = CMD_WR;
            end else if (w_pre_any) begin
                pre_gnt_o = w_pre_gnt;
                w_cmd     = CMD_PRE;
            end else if (w_ref_any) begin
                ref_gnt_o = w_ref_gnt;
                w_cmd     = CMD_REF;
            end else if (w_act_any) begin
                act_gnt_o = w_act_gnt;
                w_cmd     = CMD_ACT;
            end
            if (w_cmd == CMD_RD || w_cmd == CMD_WR) begin
                w_ba   = w_col_idx;
                w_addr = c_AW'(ca_i[w_col_idx*CA_WIDTH +: CA_WIDTH]);
            end else if (w_cmd != CMD_NOP) begin
                w_ba = w_row_idx;
                if (w_cmd == CMD_ACT) begin
                    w_addr = c_AW'(ra_i[w_row_idx*RA_WIDTH +: RA_WIDTH]);
                end
            end
        end
    end

    assign w_col_gnt = (|rd_gnt_o) | (|wr_gnt_o);
    assign w_row_gnt = (|pre_gnt_o) | (|ref_gnt_o) | (|act_gnt_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_ptr <= '0;
            r_row_ptr <= '0;
            r_valid   <= 1'b0;
            r_cmd     <= CMD_NOP;
            r_ba      <= '0;
            r_addr    <= '0;
        end else begin
            if (w_col_gnt) r_col_ptr <= w_col_idx + 1'b1;
            if (w_row_gnt) r_row_ptr <= w_row_idx + 1'b1;
            r_valid <= (w_cmd != CMD_NOP);
            r_cmd   <= w_cmd;
            r_ba    <= w_ba;
            r_addr  <= w_addr;
        end
    end

    sal_timing_cntr #(.T_WIDTH(T_WIDTH)) u_cnt_rrd (
        .clk(clk), .rst(rst), .load_i(|act_gnt_o), .val_i(t_rrd_i), .zero_o(w_rrd_zero));
    sal_timing_cntr #(.T_WIDTH(T_WIDTH)) u_cnt_ccd (
        .clk(clk), .rst(rst), .load_i(w_col_gnt), .val_i(t_ccd_i), .zero_o(w_ccd_zero));
    sal_timing_cntr #(.T_WIDTH(T_WIDTH)) u_cnt_wtr (
        .clk(clk), .rst(rst), .load_i(|wr_gnt_o), .val_i(t_wtr_i), .zero_o(w_wtr_zero));
    sal_timing_cntr #(.T_WIDTH(T_WIDTH)) u_cnt_rtw (
        .clk(clk), .rst(rst), .load_i(|rd_gnt_o), .val_i(t_rtw_i), .zero_o(w_rtw_zero));

    assign cmd_valid_o = r_valid;
    assign cmd_o       = r_cmd;
    assign cmd_ba_o    = r_ba;
    assign cmd_addr_o  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sal_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_sal_cmd_sched
// Brief  : Directed self-checking bench for the DDR2 command scheduler.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sal_cmd_sched;

    localparam int c_ACT = 0, c_RD = 1, c_WR = 2, c_PRE = 3, c_REF = 4;
    localparam int c_CMD_NOP = 0, c_CMD_ACT = 1, c_CMD_RD = 2, c_CMD_WR = 3;
    localparam int c_CMD_PRE = 4, c_CMD_REF = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  act_req, rd_req, wr_req, pre_req, ref_req;
    logic [55:0] ra;
    logic [39:0] ca;
    logic [3:0]  t_rrd, t_ccd, t_wtr, t_rtw;
    logic [3:0]  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  cmd_ba;
    logic [13:0] cmd_addr;

    int n_chk  = 0;
    int n_fail = 0;

    sal_cmd_sched #(.NUM_BANKS(4), .RA_WIDTH(14), .CA_WIDTH(10), .T_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .ra_i(ra), .ca_i(ca),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .t_rrd_i(t_rrd), .t_ccd_i(t_ccd), .t_wtr_i(t_wtr), .t_rtw_i(t_rtw),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba), .cmd_addr_o(cmd_addr));

    always #5 clk = ~clk;

    wire [19:0] w_gnts = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
    wire [19:0] w_cmdv = {cmd_valid, cmd, cmd_ba, cmd_addr};

    function automatic logic [19:0] eg(input int cls, input int bank);
        logic [19:0] v;
        v = '0;
        if (bank >= 0) v[(4 - cls) * 4 + bank] = 1'b1;
        return v;
    endfunction

    function automatic logic [19:0] ec(input int code, input int ba_v, input logic [13:0] addr);
        logic [2:0] c3;
        logic [1:0] b2;
        c3 = code[2:0];
        b2 = ba_v[1:0];
        return {(code != 0), c3, b2, addr};
    endfunction

    function automatic logic [13:0] ra_of(input int b);
        return ra[b*14 +: 14];
    endfunction

    function automatic logic [13:0] ca_of(input int b);
        return {4'b0, ca[b*10 +: 10]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        act_req = 4'hF; rd_req = 4'hF; wr_req = 4'hF; pre_req = 4'hF; ref_req = 4'hF;
        #1;
        n_chk++;
        if (w_gnts !== 20'h0) begin
            n_fail++; $display("FAIL reset_gnt got %h want %h", w_gnts, 20'h0);
        end
        tick();
        tick();
        n_chk++;
        if (w_cmdv !== 20'h0) begin
            n_fail++; $display("FAIL reset_cmd got %h want %h", w_cmdv, 20'h0);
        end
        do_reset();
    endtask

    task automatic test_rd_rr();
        int bank, prev;
        logic [19:0] exp_c;
        do_reset();
        t_ccd = 4'd1;
        rd_req = 4'b0101;
        prev = -1;
        for (int c = 0; c < 6; c++) begin
            #1;
            bank = (c % 2 == 0) ? 0 : 2;
            exp_c = (prev < 0) ? 20'h0 : ec(c_CMD_RD, prev, ca_of(prev));
            n_chk++;
            if (w_gnts !== eg(c_RD, bank)) begin
                n_fail++; $display("FAIL rd_rr_gnt c%0d got %h want %h", c, w_gnts, eg(c_RD, bank));
            end
            n_chk++;
            if (w_cmdv !== exp_c) begin
                n_fail++; $display("FAIL rd_rr_cmd c%0d got %h want %h", c, w_cmdv, exp_c);
            end
            prev = bank;
            tick();
        end
    endtask

    task automatic test_act_rrd();
        int bank, prev;
        logic [19:0] exp_c;
        do_reset();
        t_rrd = 4'd3;
        act_req = 4'hF;
        prev = -1;
        for (int c = 0; c < 11; c++) begin
            #1;
            bank = (c % 3 == 0) ? c / 3 : -1;
            exp_c = (prev < 0) ? 20'h0 : ec(c_CMD_ACT, prev, ra_of(prev));
            n_chk++;
            if (w_gnts !== eg(c_ACT, bank)) begin
                n_fail++; $display("FAIL act_rrd_gnt c%0d got %h want %h", c, w_gnts, eg(c_ACT, bank));
            end
            n_chk++;
            if (w_cmdv !== exp_c) begin
                n_fail++; $display("FAIL act_rrd_cmd c%0d got %h want %h", c, w_cmdv, exp_c);
            end
            prev = bank;
            tick();
        end
    endtask

    task automatic test_class_priority();
        logic [19:0] exp_g [4];
        logic [19:0] exp_c [4];
        exp_g[0] = eg(c_WR, 1);  exp_c[0] = 20'h0;
        exp_g[1] = eg(c_PRE, 2); exp_c[1] = ec(c_CMD_WR, 1, ca_of(1));
        exp_g[2] = eg(c_ACT, 3); exp_c[2] = ec(c_CMD_PRE, 2, 14'h0);
        exp_g[3] = 20'h0;        exp_c[3] = ec(c_CMD_ACT, 3, ra_of(3));
        do_reset();
        wr_req = 4'b0010; pre_req = 4'b0100; act_req = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) wr_req = '0;
            if (c >= 2) pre_req = '0;
            if (c >= 3) act_req = '0;
            #1;
            n_chk++;
            if (w_gnts !== exp_g[c]) begin
                n_fail++; $display("FAIL prio_gnt c%0d got %h want %h", c, w_gnts, exp_g[c]);
            end
            n_chk++;
            if (w_cmdv !== exp_c[c]) begin
                n_fail++; $display("FAIL prio_cmd c%0d got %h want %h", c, w_cmdv, exp_c[c]);
            end
            tick();
        end
    endtask

    task automatic test_wtr_rtw();
        do_reset();
        t_wtr = 4'd4; t_ccd = 4'd2;
        wr_req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                wr_req = '0; rd_req = 4'b0001;
            end
            #1;
            n_chk++;
            if (w_gnts !== ((c == 0) ? eg(c_WR, 0) : (c == 4) ? eg(c_RD, 0) : 20'h0)) begin
                n_fail++; $display("FAIL wtr_gnt c%0d got %h", c, w_gnts);
            end
            tick();
        end
        do_reset();
        t_rtw = 4'd3; t_ccd = 4'd2;
        rd_req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                rd_req = '0; wr_req = 4'b0001;
            end
            #1;
            n_chk++;
            if (w_gnts !== ((c == 0) ? eg(c_RD, 0) : (c == 3) ? eg(c_WR, 0) : 20'h0)) begin
                n_fail++; $display("FAIL rtw_gnt c%0d got %h", c, w_gnts);
            end
            if (c == 1) begin
                n_chk++;
                if (w_cmdv !== ec(c_CMD_RD, 0, ca_of(0))) begin
                    n_fail++; $display("FAIL rtw_cmd got %h want %h", w_cmdv, ec(c_CMD_RD, 0, ca_of(0)));
                end
            end
            tick();
        end
    endtask

    task automatic test_ref_act();
        logic [19:0] exp_g [4];
        logic [19:0] exp_c [4];
        exp_g[0] = eg(c_ACT, 1); exp_c[0] = 20'h0;
        exp_g[1] = eg(c_REF, 0); exp_c[1] = ec(c_CMD_ACT, 1, ra_of(1));
        exp_g[2] = 20'h0;        exp_c[2] = ec(c_CMD_REF, 0, 14'h0);
        exp_g[3] = eg(c_ACT, 1); exp_c[3] = 20'h0;
        do_reset();
        t_rrd = 4'd3;
        act_req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            ref_req = (c == 1) ? 4'b0001 : 4'b0000;
            #1;
            n_chk++;
            if (w_gnts !== exp_g[c]) begin
                n_fail++; $display("FAIL ref_act_gnt c%0d got %h want %h", c, w_gnts, exp_g[c]);
            end
            n_chk++;
            if (w_cmdv !== exp_c[c]) begin
                n_fail++; $display("FAIL ref_act_cmd c%0d got %h want %h", c, w_cmdv, exp_c[c]);
            end
            tick();
        end
        act_req = '0;
    endtask

    task automatic test_rst_collide();
        do_reset();
        t_rrd = 4'd5;
        act_req = 4'b0100;
        #1;
        n_chk++;
        if (w_gnts !== eg(c_ACT, 2)) begin
            n_fail++; $display("FAIL rstc_pre got %h want %h", w_gnts, eg(c_ACT, 2));
        end
        tick();
        rst = 1'b1;
        act_req = 4'hF;
        #1;
        n_chk++;
        if (w_gnts !== 20'h0) begin
            n_fail++; $display("FAIL rstc_gnt got %h want %h", w_gnts, 20'h0);
        end
        n_chk++;
        if (w_cmdv !== ec(c_CMD_ACT, 2, ra_of(2))) begin
            n_fail++; $display("FAIL rstc_cmd0 got %h want %h", w_cmdv, ec(c_CMD_ACT, 2, ra_of(2)));
        end
        tick();
        rst = 1'b0;
        #1;
        n_chk++;
        if (w_cmdv !== 20'h0) begin
            n_fail++; $display("FAIL rstc_cmd1 got %h want %h", w_cmdv, 20'h0);
        end
        n_chk++;
        if (w_gnts !== eg(c_ACT, 0)) begin
            n_fail++; $display("FAIL rstc_gnt1 got %h want %h", w_gnts, eg(c_ACT, 0));
        end
        tick();
        #1;
        n_chk++;
        if (w_cmdv !== ec(c_CMD_ACT, 0, ra_of(0))) begin
            n_fail++; $display("FAIL rstc_cmd2 got %h want %h", w_cmdv, ec(c_CMD_ACT, 0, ra_of(0)));
        end
        n_chk++;
        if (w_gnts !== 20'h0) begin
            n_fail++; $display("FAIL rstc_gnt2 got %h want %h", w_gnts, 20'h0);
        end
        act_req = '0;
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin
            ra[b*14 +: 14] = 14'h1000 + 14'(b * 'h111);
            ca[b*10 +: 10] = 10'h200 + 10'(b * 'h11);
        end
        rst = 1'b1;
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        tick();
        test_reset();
        test_rd_rr();
        test_act_rrd();
        test_class_priority();
        test_wtr_rtw();
        test_ref_act();
        test_rst_collide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sal_cmd_sched.md
Name: sal_cmd_sched

Overview:
- Command scheduler for one DDR2 rank. Arbitrates ACT/RD/WR/PRE/REF requests from NUM_BANKS per-bank controllers.
- Enforces inter-bank and bus-level timing: tRRD, tCCD, tWTR, tRTW.
- Issues at most one command per cycle on a registered DRAM command bus.
- Per-bank timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) stays in the bank controllers; this block only gates shared-resource timing.

Parameters:
- NUM_BANKS, 4, number of bank controllers/requesters (power of 2, 2..8).
- RA_WIDTH, 14, row address width.
- CA_WIDTH, 10, column address width.
- T_WIDTH, 4, width of each timing-parameter input and counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- act_req_i  in  NUM_BANKS  per-bank ACT request
- rd_req_i  in  NUM_BANKS  per-bank RD request
- wr_req_i  in  NUM_BANKS  per-bank WR request
- pre_req_i  in  NUM_BANKS  per-bank PRE request
- ref_req_i  in  NUM_BANKS  per-bank REF request
- ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
- ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address, same packing
- act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o  out  NUM_BANKS each  per-bank grants, combinational
- t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i  in  T_WIDTH each  timing values in clk cycles (quasi-static)
- cmd_valid_o  out  1  command bus carries a non-NOP command
- cmd_o  out  3  command code (sal_cmd_t)
- cmd_ba_o  out  $clog2(NUM_BANKS)  bank address
- cmd_addr_o  out  max(RA_WIDTH,CA_WIDTH)  RA for ACT, CA for RD/WR (zero-extended), 0 otherwise

Behaviour:
- Single clock clk; reset rst is synchronous, active-high; rst wins over any same-cycle grant.
- Reset state:
  - cmd_valid_o=0, cmd_o=NOP, cmd_ba_o=0, cmd_addr_o=0.
  - All timing counters 0; both RR pointers 0.
- Grants:
  - Combinational from current requests plus registered state.
  - At most one grant bit asserted across all five vectors per cycle.
  - No grant while rst=1.
- Eligibility:
  - RD: tCCD counter==0 and tWTR counter==0.
  - WR: tCCD counter==0 and tRTW counter==0.
  - ACT: tRRD counter==0.
  - PRE and REF: always eligible.
- Class priority: column (RD/WR) > PRE > REF > ACT.
  - If one bank raises several requests, the same priority applies; bank controllers normally raise one.
- Round-robin:
  - Two independent pointers: col_ptr (RD/WR) and row_ptr (PRE/REF/ACT).
  - Within a class, the first eligible requesting bank at or after the pointer wins, wrapping NUM_BANKS-1 -> 0.
  - On a grant in a class group, that group's pointer moves to (winner+1) mod NUM_BANKS; the other pointer holds.
- Timing counters:
  - On grant, load max(t-1,0); otherwise decrement each cycle, saturating at 0.
  - ACT grant loads tRRD; RD or WR grant loads tCCD; WR grant loads tWTR; RD grant loads tRTW.
  - t=0 or t=1 means back-to-back issue is allowed.
  - A reload in the same cycle as a decrement takes the load value.
- Command bus latency: the grant in cycle N appears on cmd_*_o in cycle N+1.
  - Without a grant, cycle N+1 shows cmd_valid_o=0, cmd_o=NOP, and cmd_ba_o/cmd_addr_o=0.
- Requests may drop without a grant; nothing is latched until grant.
- The scheduler never checks per-bank state; a bank that requests illegally is still granted.

Decomposition:
- Shared package sal_sched_pkg holds:
  - sal_cmd_t: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5.
  - localparam BA_WIDTH = $clog2(NUM_BANKS).
  - cmd_addr width helper.
- Sub-module sal_rr_arbiter (NUM_BANKS-wide request vector, pointer input, one-hot grant plus winner index output).
  - Instantiated once per class: RD, WR, PRE, REF, ACT.
  - Class-priority muxing is done in the top level.
- Timing counters reuse the existing SAL_TIMING_CNTR primitive.

Test Plan:
- Reset, then rd_req_i=4'b0101 held.
  -> rd_gnt_o=0001, 0100, 0001, ... each cycle (t_ccd=1).
  -> cmd_o=RD, cmd_ba_o=0,2,0 from the next cycle.
- t_rrd=3; act_req_i=4'b1111 held, other requests low.
  -> ACT grants at cycles 0, 3, 6, 9 to banks 0,1,2,3.
  -> cmd_addr_o=ra_i of the granted bank one cycle later.
- Same cycle: wr_req bank1, pre_req bank2, act_req bank3.
  -> wr_gnt_o=0010 first, pre_gnt_o=0100 next, act_gnt_o=1000 third.
- WR grant at cycle 0 with t_wtr=4, t_ccd=2; rd_req bank0 from cycle 1.
  -> no rd_gnt at cycles 1-3; rd_gnt_o=0001 at cycle 4.
  -> Swap roles with t_rtw=3: wr_gnt at cycle 3.
- ref_req bank0 plus act_req bank1 with tRRD counter nonzero.
  -> ref_gnt_o=0001 immediately.
  -> Next cycle, act is still blocked until tRRD expires.
- rst asserted in the same cycle as an active act_req.
  -> no grant that cycle.
  -> Next cycle cmd_valid_o=0, counters 0, pointers 0, and ACT is granted to bank 0 first.
